alu_writeback: RTL

- Receiving end of the ALU result path: takes 16-bit results plus NZCV from the ALU stage over a valid/ready handshake.
- Buffers them in a small in-order FIFO and writes results to the register file through a stallable write port.
- Commits flag-writing entries into the architectural NZCV status register.
- Evaluates 4-bit branch condition codes against the committed flags, and exposes pending-destination hazard information to the issue stage.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_cond_eval.sv | 44 ++++
 rtl/alu_writeback.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, NZCV bit positions, opcodes and
// branch condition codes used by the ALU, writeback and branch units.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  // Bit positions inside a 4-bit {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ALU opcodes, kept here so the ALU and its consumers agree on encoding.
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_CMP = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;

  // Branch condition codes.
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational branch-condition evaluator: decides whether a 4-bit
// condition code holds for a given NZCV flag set. Shared with the branch unit.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       true_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  // Decode the condition code against the flags.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives the
    // output, so no latch is inferred.
    true_o = 1'b0;
    case (cond_i)
      COND_EQ: true_o = z;
      COND_NE: true_o = !z;
      COND_CS: true_o = c;
      COND_CC: true_o = !c;
      COND_MI: true_o = n;
      COND_PL: true_o = !n;
      COND_VS: true_o = v;
      COND_VC: true_o = !v;
      COND_HI: true_o = c && !z;
      COND_LS: true_o = !c || z;
      COND_GE: true_o = (n == v);
      COND_LT: true_o = (n != v);
      COND_GT: true_o = !z && (n == v);
      COND_LE: true_o = z || (n != v);
      COND_AL: true_o = 1'b1;
      COND_NV: true_o = 1'b0;
      default: true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers ALU results in a small in-order FIFO, drains
// them through a stallable register-file write port, commits flag updates to
// the architectural NZCV register and reports hazards to the issue stage.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_result,
  input  logic [3:0]           in_nzcv,
  input  logic [REG_AW-1:0]    in_rd,
  input  logic                 in_rd_we,
  input  logic                 in_flag_we,
  output logic                 rf_we,
  output logic [REG_AW-1:0]    rf_addr,
  output logic [WIDTH-1:0]     rf_wdata,
  input  logic                 rf_ready,
  output logic [3:0]           flags,
  input  logic [3:0]           cond,
  output logic                 cond_valid,
  output logic                 cond_true,
  output logic [2**REG_AW-1:0] pending_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // FIFO payload storage.
  logic [WIDTH-1:0]  result_mem [DEPTH];
  logic [3:0]        nzcv_mem   [DEPTH];
  logic [REG_AW-1:0] rd_mem     [DEPTH];
  logic [DEPTH-1:0]  rd_we_mem;
  logic [DEPTH-1:0]  flag_we_mem;

  // Control state.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [3:0]       flags_q, flags_d;

  logic push, pop, not_empty;
  logic head_rd_we, head_flag_we;
  logic flag_pending;
  logic eval_true;

  // Handshake and head-of-queue decisions.
  always_comb begin
    in_ready     = (count_q != FULL_CNT);
    push         = in_valid && in_ready;
    not_empty    = (count_q != '0);
    head_rd_we   = rd_we_mem[rd_ptr_q];
    head_flag_we = flag_we_mem[rd_ptr_q];
    // Non-writing entries leave after one cycle; writers wait for the port.
    pop          = not_empty && (!head_rd_we || rf_ready);
  end

  // Next-state for pointers, occupancy, slot valid bits and committed flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    flags_d  = flags_q;
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
      if (head_flag_we) flags_d = nzcv_mem[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset flushes the queue and clears the flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      flags_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      flags_q  <= flags_d;
    end
  end

  // Payload write on accept.
  // NOTE: payload storage is deliberately not reset; occupancy is tracked by
  // valid_q/count_q, which are, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      result_mem[wr_ptr_q]  <= in_result;
      nzcv_mem[wr_ptr_q]    <= in_nzcv;
      rd_mem[wr_ptr_q]      <= in_rd;
      rd_we_mem[wr_ptr_q]   <= in_rd_we;
      flag_we_mem[wr_ptr_q] <= in_flag_we;
    end
  end

  // Hazard summary over the buffered entries only.
  always_comb begin
    pending_rd   = '0;
    flag_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && rd_we_mem[i]) pending_rd[rd_mem[i]] = 1'b1;
      if (valid_q[i] && flag_we_mem[i]) flag_pending = 1'b1;
    end
  end

  assign rf_we      = not_empty && head_rd_we;
  assign rf_addr    = rd_mem[rd_ptr_q];
  assign rf_wdata   = result_mem[rd_ptr_q];
  assign flags      = flags_q;
  assign cond_valid = !flag_pending;
  assign cond_true  = cond_valid && eval_true;

  alu_cond_eval u_cond_eval (
    .cond_i (cond),
    .nzcv_i (flags_q),
    .true_o (eval_true)
  );

endmodule
